// File: rtl/mmio_if_pio_poller.sv
// Autonomous Avalon-MM poller for an 8-bit input PIO: periodic read, debounce,
// sticky edge capture and a masked level interrupt behind a 4-register CPU slave.
module mmio_if_pio_poller #(
  parameter int POLL_DIV = 1000,
  parameter int DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int               DIV_W    = $clog2(POLL_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_EDGE = 2'd2;
  localparam logic [1:0] A_MASK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CMP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_en;
  logic [DIV_W-1:0] r_div_cnt;
  logic [7:0]       r_sample;
  logic [7:0]       r_cand;
  logic [3:0]       r_stable;
  logic [7:0]       r_data;
  logic [7:0]       r_edge;
  logic [7:0]       r_mask;
  logic [31:0]      r_rdata;

  logic             w_tick;
  logic [3:0]       w_stable_nx;
  logic             w_accept;
  logic [7:0]       w_edge_set;
  logic [7:0]       w_w1c;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Only the low byte of either data bus carries meaning.
  assign w_unused = ^{m_readdata[31:8], s_writedata[31:8]};

  assign w_tick = r_en && (r_div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_tick) w_state_nx = ST_REQ;
      ST_REQ:  w_state_nx = ST_WAIT;
      ST_WAIT: w_state_nx = ST_CMP;
      ST_CMP:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    m_read    = (r_state == ST_REQ);
    m_address = 2'd0;
  end

  // Divider: held at zero while disabled, so re-enabling always restarts a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (!r_en || (r_div_cnt == DIV_LAST)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Debounce: the updated run length decides acceptance within the same CMP cycle.
  always_comb begin
    w_stable_nx = 4'd1;
    if (r_sample == r_cand) begin
      w_stable_nx = (r_stable >= DB_MAX) ? DB_MAX : r_stable + 4'd1;
    end
  end

  assign w_accept   = (r_state == ST_CMP) && (w_stable_nx == DB_MAX) && (r_sample != r_data);
  assign w_edge_set = w_accept ? (r_data ^ r_sample) : 8'h00;
  assign w_w1c      = (s_write && (s_address == A_EDGE)) ? s_writedata[7:0] : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= 8'h00;
      r_cand   <= 8'h00;
      r_stable <= 4'd0;
      r_data   <= 8'h00;
      r_edge   <= 8'h00;
    end else begin
      if (r_state == ST_WAIT) begin
        r_sample <= m_readdata[7:0];
      end
      if (r_state == ST_CMP) begin
        r_cand   <= r_sample;
        r_stable <= w_stable_nx;
      end
      if (w_accept) begin
        r_data <= r_sample;
      end
      // A new edge beats a simultaneous clear of the same bit.
      r_edge <= (r_edge & ~w_w1c) | w_edge_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en   <= 1'b0;
      r_mask <= 8'h00;
    end else if (s_write) begin
      if (s_address == A_CTRL) r_en   <= s_writedata[0];
      if (s_address == A_MASK) r_mask <= s_writedata[7:0];
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    unique case (s_address)
      A_DATA: w_rdata = {24'h0, r_data};
      A_CTRL: w_rdata = {31'h0, r_en};
      A_EDGE: w_rdata = {24'h0, r_edge};
      A_MASK: w_rdata = {24'h0, r_mask};
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'h0;
    end else if (s_read) begin
      r_rdata <= w_rdata;
    end
  end

  assign s_readdata = r_rdata;
  assign irq        = |(r_edge & r_mask);

endmodule
